interval_timer: RTL
===================

INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 Parameter: CLK_DIV, default 1_000_000, clock cycles per one-second tick (minimum 2).
REQ-002 Parameter: BASE_DEF, default 6, reset value of the base interval in seconds.
REQ-003 Parameter: EXT_DEF, default 3, reset value of the extended interval in seconds.
REQ-004 Parameter: YEL_DEF, default 2, reset value of the yellow interval in seconds.
REQ-005 clk  in  1  single system clock, rising edge.
REQ-006 Reset_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
REQ-007 Start_Timer  in  1  level from controller; a rising edge requests a countdown.
REQ-008 Interval  in  2  interval select sampled at start: 00 base, 01 extended, 10 yellow, 11 base.
REQ-009 Reprogram  in  1  synchronous write strobe for a time parameter.
REQ-010 Time_Param_Sel  in  2  parameter to write: 00 base, 01 extended, 10 yellow, 11 ignored.
REQ-011 Time_Value  in  4  new value in seconds, 1..15.
REQ-012 Expired  out  1  one-cycle pulse when the countdown completes.
REQ-013 Busy  out  1  high while counting.
REQ-014 Remaining  out  4  whole seconds left; 0 when idle.

Function
REQ-015 States: IDLE, COUNT, DONE; registered outputs only.
REQ-016 Start edge detected as Start_Timer high this cycle and low in the previous registered sample; a held level never retriggers.
REQ-017 In IDLE, a start edge in cycle k loads Remaining with the selected value, clears the prescaler and enters COUNT in cycle k+1.
REQ-018 In COUNT, the prescaler counts 0..CLK_DIV-1; at wrap Remaining decrements by 1.
REQ-019 When Remaining reaches 0, enter DONE; Expired is high exactly N*CLK_DIV cycles after cycle k, for one cycle; the next state is IDLE.
REQ-020 A start edge in COUNT or DONE restarts the countdown, with the same timing as REQ-017; a DONE-cycle restart still emits that Expired pulse.
REQ-021 Reprogram with Time_Value 0 or Time_Param_Sel 11 is ignored; otherwise the selected register updates at the next edge.
REQ-022 Reprogram during COUNT does not alter the running countdown; the new value applies from the next start.
REQ-023 Reprogram and start edge in the same cycle: the start loads the old value.
REQ-024 Busy is high in COUNT and low in IDLE/DONE; Remaining is held at 0 in IDLE.

Reset
REQ-025 On Reset_n low, immediately: state IDLE, Expired 0, Busy 0, Remaining 0, prescaler 0, edge-detect register 0, registers = BASE_DEF/EXT_DEF/YEL_DEF.
REQ-026 Reset asserted mid-countdown aborts it with no Expired pulse; after release, a start edge is needed to count.
REQ-027 Start_Timer held high across reset release does not count as an edge.

Structure
REQ-028 A shared package holds the Interval codes (INT_BASE, INT_EXT, INT_YEL), the Time_Param_Sel codes and the state encoding, for use with the controller.
REQ-029 One sub-module, sec_prescaler (CLK_DIV counter, synchronous clear, one-cycle tick output), is instantiated.
REQ-030 The expected implementation size is 120-250 lines of RTL.

Verification (CLK_DIV=4)
REQ-031 Start edge with Interval=00 at defaults -> Expired pulses once exactly 24 cycles later; Busy high for 23 cycles before it.
REQ-032 Start_Timer held high for 40 cycles with Interval=10 -> exactly one Expired, 8 cycles after the edge.
REQ-033 Reprogram Sel=01, Value=5, then start with Interval=01 -> Expired after 20 cycles; Value=0 write -> extended interval stays 5.
REQ-034 Start Interval=00, new start edge with Interval=10 at cycle 10 -> no expiry at cycle 24; Expired at cycle 18.
REQ-035 Reset_n low at cycle 12 of a base countdown -> outputs 0 immediately, no Expired; registers return to 6/3/2.
REQ-036 Reprogram Sel=00 Value=9 in the same cycle as a start with Interval=00 -> Expired at 24 cycles; the next base start gives 36 cycles.

Source files
------------

// File: rtl/interval_timer_pkg.sv
// rtl/interval_timer_pkg.sv - shared codes and state encoding for the interval timer
package interval_timer_pkg;

    localparam logic [1:0] INT_BASE = 2'b00;
    localparam logic [1:0] INT_EXT  = 2'b01;
    localparam logic [1:0] INT_YEL  = 2'b10;

    localparam logic [1:0] SEL_BASE = 2'b00;
    localparam logic [1:0] SEL_EXT  = 2'b01;
    localparam logic [1:0] SEL_YEL  = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COUNT = 2'b01,
        ST_DONE  = 2'b10
    } timer_state_t;

    // Code 11 falls back to the base interval.
    function automatic logic [3:0] pick_interval(
        input logic [1:0] code,
        input logic [3:0] base_s,
        input logic [3:0] ext_s,
        input logic [3:0] yel_s
    );
        case (code)
            INT_EXT: pick_interval = ext_s;
            INT_YEL: pick_interval = yel_s;
            default: pick_interval = base_s;
        endcase
    endfunction

endpackage

// File: rtl/interval_timer_prescaler.sv
// rtl/interval_timer_prescaler.sv - one-second prescaler (module sec_prescaler)
module sec_prescaler #(
    parameter int CLK_DIV = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLK_DIV - 2);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // Fires one cycle ahead of the wrap so that the registered countdown
    // outputs change exactly on the second boundary.
    assign tick = en && !clr && (count_q == PRE);

endmodule

// File: rtl/interval_timer.sv
// rtl/interval_timer.sv - start-edge triggered seconds countdown with programmable intervals
module interval_timer
    import interval_timer_pkg::*;
#(
    parameter int CLK_DIV  = 1_000_000,
    parameter int BASE_DEF = 6,
    parameter int EXT_DEF  = 3,
    parameter int YEL_DEF  = 2
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic       Start_Timer,
    input  logic [1:0] Interval,
    input  logic       Reprogram,
    input  logic [1:0] Time_Param_Sel,
    input  logic [3:0] Time_Value,
    output logic       Expired,
    output logic       Busy,
    output logic [3:0] Remaining
);

    timer_state_t state_q;
    timer_state_t state_d;
    logic [3:0]   rem_d;
    logic [3:0]   base_q;
    logic [3:0]   ext_q;
    logic [3:0]   yel_q;
    logic         start_prev_q;
    logic         start_armed_q;
    logic         start_edge;
    logic         tick;

    // Armed only once Start_Timer has been seen low, so a level held through
    // reset release is not mistaken for a new request.
    assign start_edge = Start_Timer && !start_prev_q && start_armed_q;

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            start_prev_q  <= 1'b0;
            start_armed_q <= 1'b0;
        end else begin
            start_prev_q <= Start_Timer;
            if (!Start_Timer) begin
                start_armed_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            base_q <= 4'(BASE_DEF);
            ext_q  <= 4'(EXT_DEF);
            yel_q  <= 4'(YEL_DEF);
        end else if (Reprogram && (Time_Value != 4'd0)) begin
            case (Time_Param_Sel)
                SEL_BASE: base_q <= Time_Value;
                SEL_EXT:  ext_q  <= Time_Value;
                SEL_YEL:  yel_q  <= Time_Value;
                default:  ;
            endcase
        end
    end

    sec_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_sec_prescaler (
        .clk   (clk),
        .rst_n (Reset_n),
        .clr   (start_edge),
        .en    (state_q == ST_COUNT),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = Remaining;
        if (start_edge) begin
            state_d = ST_COUNT;
            rem_d   = pick_interval(Interval, base_q, ext_q, yel_q);
        end else begin
            case (state_q)
                ST_COUNT: begin
                    if (tick) begin
                        rem_d = Remaining - 4'd1;
                        if (Remaining == 4'd1) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    rem_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            Remaining <= 4'd0;
            Busy      <= 1'b0;
            Expired   <= 1'b0;
        end else begin
            state_q   <= state_d;
            Remaining <= rem_d;
            Busy      <= (state_d == ST_COUNT);
            Expired   <= (state_d == ST_DONE);
        end
    end

endmodule
